// File: rtl/xfer_sched_pkg.sv
// Shared types and constants for the xfer_sched round-robin transfer scheduler.
package xfer_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_GAP   = 3'd2;
    localparam state_t S_START = 3'd3;
    localparam state_t S_RUN   = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam int GAP_W = 8;

    // Requester index width; a single requester still needs one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xfer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           enable,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] c;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        c   = '0;
        if (enable) begin
            for (int k = N - 1; k >= 0; k--) begin
                c = IDW'((int'(ptr) + k) % N);
                if (req[c]) begin
                    gnt    = '0;
                    gnt[c] = 1'b1;
                    idx    = c;
                end
            end
        end
    end

endmodule

// File: rtl/xfer_sched.sv
// Round-robin scheduler sharing one size-count engine between N requesters.
// Define XFER_TIMEOUT_EN to add the RUN-state watchdog (timeout_err, eng_rst_n).
module xfer_sched
    import xfer_sched_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int SIZE_W    = 32,
    parameter  int START_DLY = 0,
    parameter  int TIMEOUT   = 1024,
    localparam int IDW       = idw(N)
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic [N*SIZE_W-1:0] req_size,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        done,
    output logic                busy,
    output logic [IDW-1:0]      cur_id,
    output logic                eng_size_valid,
    output logic [SIZE_W-1:0]   eng_size,
    output logic                eng_data_start,
`ifdef XFER_TIMEOUT_EN
    output logic                timeout_err,
    output logic                eng_rst_n,
`endif
    input  logic                eng_last
);

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    id_q;
    logic [N-1:0]      gnt_q;
    logic [SIZE_W-1:0] size_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [N-1:0]      arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic [IDW-1:0]    next_ptr;
    logic [SIZE_W-1:0] sizes [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign sizes[i] = req_size[i*SIZE_W +: SIZE_W];
    end

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .enable (state == S_IDLE),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    assign next_ptr = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

`ifdef XFER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    logic [TO_W-1:0] run_cnt;
    logic            err_q;
    logic            expire;

    // The engine reset is decoded from state alone, so it also pulses when eng_last
    // lands on the expiry cycle; the transfer then still completes normally.
    assign expire      = (state == S_RUN) && (run_cnt == TO_W'(TIMEOUT - 1));
    assign eng_rst_n   = ~expire;
    assign timeout_err = err_q;
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            size_q  <= '0;
            gap_cnt <= '0;
`ifdef XFER_TIMEOUT_EN
            run_cnt <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt_q  <= arb_gnt;
                        id_q   <= arb_idx;
                        size_q <= sizes[arb_idx];
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (START_DLY == 0) begin
                        state <= S_START;
                    end else begin
                        gap_cnt <= GAP_W'(START_DLY);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) state <= S_START;
                end
                S_START: begin
`ifdef XFER_TIMEOUT_EN
                    run_cnt <= '0;
`endif
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (eng_last) begin
                        state <= S_DONE;
                    end
`ifdef XFER_TIMEOUT_EN
                    else if (expire) begin
                        gnt_q <= '0;
                        ptr   <= next_ptr;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end
                    run_cnt <= run_cnt + TO_W'(1);
`endif
                end
                S_DONE: begin
                    ptr   <= next_ptr;
                    gnt_q <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign cur_id         = id_q;
    assign busy           = (state != S_IDLE);
    assign eng_size_valid = (state == S_LOAD);
    assign eng_size       = size_q;
    assign eng_data_start = (state == S_START);
    assign done           = (state == S_DONE) ? gnt_q : '0;

endmodule

// File: doc/xfer_sched.md
Name: xfer_sched

Overview:
- Round-robin scheduler that shares one size-count engine between N requesters.
- Per transfer:
  - picks one requester;
  - loads that requester's size into the engine;
  - issues the engine's start strobe;
  - waits for the engine's last pulse;
  - signals completion back to the requester.
- Sits between the requester front-ends and the engine, which consumes size_valid/size/data_start and returns last.

Parameters:
- N, 4, number of requesters (2..16).
- SIZE_W, 32, width of each requester's size field and of eng_size.
- START_DLY, 0, idle cycles between the size-load strobe and the start strobe (0..255).
- TIMEOUT, 1024, cycles allowed in RUN before abort (used only with XFER_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  N  per-requester transfer request (level)
- req_size  in  N*SIZE_W  per-requester size; slice i = bits [i*SIZE_W +: SIZE_W]
- gnt  out  N  one-hot grant, held from LOAD through DONE
- done  out  N  one-cycle completion pulse to the granted requester
- busy  out  1  high in any state other than IDLE
- cur_id  out  IDW  index of the granted requester; IDW = max(1, clog2(N))
- eng_size_valid  out  1  engine size-load strobe
- eng_size  out  SIZE_W  size presented to the engine
- eng_data_start  out  1  engine start strobe
- eng_last  in  1  engine completion pulse
- timeout_err  out  1  sticky error (only with XFER_TIMEOUT_EN)
- eng_rst_n  out  1  engine reset request (only with XFER_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0, except eng_rst_n = 1. State = IDLE, round-robin pointer = 0, size register = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- States: IDLE, LOAD, GAP, START, RUN, DONE.
- IDLE:
  - If req != 0, select the first set bit searching from the pointer upward, wrapping modulo N.
  - Register gnt, cur_id, and that requester's req_size slice; go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD:
  - eng_size_valid = 1 and eng_size = latched size, for exactly one cycle.
  - If START_DLY == 0, go to START; otherwise load the gap counter with START_DLY and go to GAP.
- GAP: decrement the counter each cycle; go to START when it reaches 1.
- START: eng_data_start = 1 for one cycle; go to RUN.
- RUN:
  - Stay until eng_last == 1, then go to DONE.
  - eng_last seen in any state other than RUN is ignored.
- DONE:
  - done[cur_id] = 1 for one cycle; gnt is still high in this cycle.
  - Pointer becomes (cur_id + 1) mod N. Go to IDLE; gnt clears on that transition.
- Latency:
  - req sampled at edge t gives eng_size_valid in cycle t+1 and eng_data_start in cycle t+2+START_DLY.
  - done is asserted in the cycle after eng_last.
  - Minimum IDLE-to-IDLE overhead is 4 cycles plus START_DLY plus engine time.
- Fairness: a requester that keeps req high is served at most once per N grants while others are pending.
- Requester protocol:
  - req should stay high until done.
  - Dropping req after grant does not cancel the transfer.
  - req_size is sampled only in IDLE; later changes are ignored.
- Size 0 is legal and is passed through unchanged; the engine finishes immediately after start.
- Simultaneous req with DONE: the new arbitration happens in the following IDLE cycle using the updated pointer.
- rst_n low in any state forces the reset values on the next edge. No done is issued for an aborted transfer.

Optional Feature:
- Macro: XFER_TIMEOUT_EN.
- Defined:
  - A RUN-cycle counter starts at 0 on entry to RUN.
  - If it reaches TIMEOUT - 1 without eng_last:
    - eng_rst_n = 0 for one cycle;
    - timeout_err is set and stays set until rst_n;
    - done is NOT pulsed for the aborted transfer;
    - the pointer advances past cur_id and the state returns to IDLE.
  - eng_last in the same cycle as expiry wins: normal DONE.
- Not defined: the timeout_err and eng_rst_n ports do not exist; RUN waits indefinitely.

Decomposition:
- Package xfer_sched_pkg holds:
  - the state enum (IDLE, LOAD, GAP, START, RUN, DONE);
  - the IDW derivation function;
  - gap-counter width localparam (8 bits).
- Sub-module rr_arbiter:
  - inputs: req[N], pointer, enable;
  - outputs: one-hot grant and binary index;
  - purely combinational, instantiated once.
- The FSM, size latch, and counters stay in xfer_sched.

Test Plan:
- Bench engine model returns eng_last size+1 cycles after the eng_data_start cycle.
- Single request, N=4, START_DLY=0: req[2]=1 with size 3 at cycle 0 → gnt=0100 and eng_size_valid with eng_size=3 in cycle 1; eng_data_start in cycle 2; eng_last in cycle 6; done=0100 in cycle 7; IDLE in cycle 8.
- All four requesters held high, sizes 1, 2, 3, 4 → grant order 0, 1, 2, 3, 0; each done matches its gnt; no requester is granted twice within four grants.
- START_DLY=5, req[1] with size 0 → eng_data_start exactly 6 cycles after eng_size_valid; done follows.
- Stray eng_last pulses in IDLE and GAP, and req_size changed during RUN → no state change; eng_size keeps the value latched at grant.
- rst_n low during RUN → all outputs 0, no done, pointer 0; the next req[3] is granted normally.
- XFER_TIMEOUT_EN, TIMEOUT=16, engine never returns last:
  - eng_rst_n low for one cycle at RUN cycle 15, timeout_err set, no done, return to IDLE.
  - A second run with eng_last at RUN cycle 15 completes normally with no error.
